// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the segmented pipelined adder: stage count and segment offsets.
package pipelined_adder_pkg;

  function automatic int num_stages(input int width, input int seg_width);
    return width / seg_width;
  endfunction

  function automatic int seg_lo(input int k, input int seg_width);
    return k * seg_width;
  endfunction

endpackage

// File: rtl/pipelined_adder_seg.sv
// One registered SEG_WIDTH-bit slice of the carry chain, with valid and global advance enable.
module adder_seg
  import pipelined_adder_pkg::*;
#(
  parameter int SEG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 vld_i,
  input  logic [SEG_WIDTH-1:0] a_i,
  input  logic [SEG_WIDTH-1:0] b_i,
  input  logic                 c_i,
  output logic [SEG_WIDTH-1:0] sum_o,
  output logic                 c_o,
  output logic                 vld_o
);

  logic [SEG_WIDTH:0]   add_d;
  logic [SEG_WIDTH-1:0] sum_q;
  logic                 c_q;
  logic                 vld_q;

  assign add_d = {1'b0, a_i} + {1'b0, b_i} + {{SEG_WIDTH{1'b0}}, c_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      sum_q <= '0;
      c_q   <= 1'b0;
    end else if (en_i) begin
      vld_q <= vld_i;
      sum_q <= add_d[SEG_WIDTH-1:0];
      c_q   <= add_d[SEG_WIDTH];
    end
  end

  assign sum_o = sum_q;
  assign c_o   = c_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit a+b+c_in with the carry chain cut into SEG_WIDTH-bit registered stages and a
// valid/ready handshake. Define PIPELINED_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_ADDER_OVF_EN
  output logic             c_out,
  output logic             ovf
`else
  output logic             c_out
`endif
);

  localparam int STAGES = num_stages(WIDTH, SEG_WIDTH);

  if (SEG_WIDTH < 1 || WIDTH < SEG_WIDTH || (WIDTH % SEG_WIDTH) != 0) begin : g_param_err
    $error("pipelined_adder: WIDTH must be a positive multiple of SEG_WIDTH");
  end

  logic en;

  // Global stall: the whole pipe advances only when the output slot is free or draining.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO_W  = seg_lo(k, SEG_WIDTH);
    localparam int SRC_W = WIDTH - LO_W;
    localparam int HI_W  = SRC_W - SEG_WIDTH;

    logic [SRC_W-1:0]          a_src;
    logic [SRC_W-1:0]          b_src;
    logic                      c_src;
    logic                      vld_src;
    logic [SEG_WIDTH-1:0]      seg_sum;
    logic                      c_seg;
    logic                      vld_seg;
    logic [LO_W+SEG_WIDTH-1:0] fin;

    if (k == 0) begin : g_head
      assign a_src   = a;
      assign b_src   = b;
      assign c_src   = c_in;
      assign vld_src = in_valid;
      assign fin     = seg_sum;
    end else begin : g_body
      logic [LO_W-1:0] done_q;

      assign a_src   = g_stg[k-1].g_hi.a_hi_q;
      assign b_src   = g_stg[k-1].g_hi.b_hi_q;
      assign c_src   = g_stg[k-1].c_seg;
      assign vld_src = g_stg[k-1].vld_seg;

      // Finished lower segments ride forward so they line up with this stage's result.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          done_q <= '0;
        end else if (en) begin
          done_q <= g_stg[k-1].fin;
        end
      end

      assign fin = {seg_sum, done_q};
    end

    if (HI_W > 0) begin : g_hi
      logic [HI_W-1:0] a_hi_q;
      logic [HI_W-1:0] b_hi_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
        end else if (en) begin
          a_hi_q <= a_src[SRC_W-1:SEG_WIDTH];
          b_hi_q <= b_src[SRC_W-1:SEG_WIDTH];
        end
      end
    end

    adder_seg #(
      .SEG_WIDTH(SEG_WIDTH)
    ) u_seg (
      .clk  (clk),
      .rst  (rst),
      .en_i (en),
      .vld_i(vld_src),
      .a_i  (a_src[SEG_WIDTH-1:0]),
      .b_i  (b_src[SEG_WIDTH-1:0]),
      .c_i  (c_src),
      .sum_o(seg_sum),
      .c_o  (c_seg),
      .vld_o(vld_seg)
    );
  end

  assign sum       = g_stg[STAGES-1].fin;
  assign c_out     = g_stg[STAGES-1].c_seg;
  assign out_valid = g_stg[STAGES-1].vld_seg;

`ifdef PIPELINED_ADDER_OVF_EN
  logic a_msb_q;
  logic b_msb_q;

  // Operand MSBs are captured alongside the top segment so ovf stays aligned with sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (en) begin
      a_msb_q <= g_stg[STAGES-1].a_src[SEG_WIDTH-1];
      b_msb_q <= g_stg[STAGES-1].b_src[SEG_WIDTH-1];
    end
  end

  assign ovf = (a_msb_q == b_msb_q) && (sum[WIDTH-1] != a_msb_q);
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and random checks of pipelined_adder (WIDTH=32, SEG_WIDTH=8) against a queue-based reference.
module tb_pipelined_adder;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef PIPELINED_ADDER_OVF_EN
  logic             ovf;
`endif

  exp_t             q[$];
  int               evals;
  int               fails;
  int               out_cnt;
  int               in_cnt;
  logic             in_fired;
  logic             held;
  logic [WIDTH:0]   hold_val;

  pipelined_adder #(
    .WIDTH    (WIDTH),
    .SEG_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
`ifdef PIPELINED_ADDER_OVF_EN
    .c_out    (c_out),
    .ovf      (ovf)
`else
    .c_out    (c_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    evals++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples mid-cycle, updates the scoreboard, then waits for the next falling edge.
  task automatic step();
    exp_t       e;
    logic [WIDTH:0] full;
    #2;
    check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
    if (held) check("hold_out", 64'({out_valid, c_out, sum}), 64'({1'b1, hold_val}));
    held     = out_valid && !out_ready;
    hold_val = {c_out, sum};
    in_fired = in_valid && in_ready;
    if (out_valid && out_ready) begin
      out_cnt++;
      if (q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        e = q.pop_front();
        check("sum", 64'(sum), 64'(e.s));
        check("c_out", 64'(c_out), 64'(e.c));
`ifdef PIPELINED_ADDER_OVF_EN
        check("ovf", 64'(ovf), 64'(e.o));
`endif
      end
    end
    if (in_fired) begin
      in_cnt++;
      full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
      e.s  = full[WIDTH-1:0];
      e.c  = full[WIDTH];
      e.o  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
    a         = av;
    b         = bv;
    c_in      = cv;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    check("send_accepted", 64'(in_fired), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) step();
    check("drain_empty", 64'(q.size()), 64'(0));
  endtask

  initial begin
    int cnt;
    int start;
    int guard;
    evals     = 0;
    fails     = 0;
    out_cnt   = 0;
    in_cnt    = 0;
    held      = 1'b0;
    hold_val  = '0;
    in_fired  = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_c_out", 64'(c_out), 64'(0));
`ifdef PIPELINED_ADDER_OVF_EN
    check("rst_ovf", 64'(ovf), 64'(0));
`endif
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Latency: 1 + 2 appears exactly four cycles after acceptance
    send(32'h0000_0001, 32'h0000_0002, 1'b0);
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      step();
      cnt++;
    end
    check("latency", 64'(cnt), 64'(4));
    check("latency_sum", 64'(sum), 64'(32'h0000_0003));
    check("latency_c_out", 64'(c_out), 64'(0));
    drain();

    // Carry ripple across every segment boundary
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send(32'h00FF_00FF, 32'h0001_FF01, 1'b0);
    drain();

    // Signed overflow corners
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    send(32'h0000_0001, 32'h0000_0001, 1'b0);
    drain();

    // Backpressure: 16 random sets, out_ready toggling randomly, inputs held until accepted
    start = out_cnt;
    for (int i = 0; i < 16; i++) begin
      a        = $urandom;
      b        = $urandom;
      c_in     = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      guard    = 0;
      do begin
        out_ready = 1'($urandom_range(0, 1));
        step();
        guard++;
      end while (!in_fired && guard < 50);
      check("bp_accept", 64'(in_fired), 64'(1));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    drain();
    check("bp_count", 64'(out_cnt - start), 64'(16));

    // Throughput: 100 back-to-back sets, one result per cycle after fill
    start = out_cnt;
    cnt   = in_cnt;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a    = $urandom;
      b    = $urandom;
      c_in = 1'($urandom_range(0, 1));
      step();
    end
    check("tp_accepted", 64'(in_cnt - cnt), 64'(100));
    check("tp_out_during", 64'(out_cnt - start), 64'(96));
    drain();
    check("tp_out_total", 64'(out_cnt - start), 64'(100));

    // Reset with a full, stalled pipe
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a    = 32'h1234_5678 + i;
      b    = 32'h0F0F_0F0F;
      c_in = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #1;
    check("prefill_out_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_sum", 64'(sum), 64'(0));
    check("midrst_c_out", 64'(c_out), 64'(0));
    q.delete();
    held = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    start     = out_cnt;
    for (int i = 0; i < 8; i++) step();
    check("post_rst_no_output", 64'(out_cnt - start), 64'(0));

    // Pipe still works after the mid-stream reset
    send(32'hDEAD_BEEF, 32'h2152_4111, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end

endmodule
